// File: rtl/uart_debug_monitor_pkg.sv
// Shared state/response types, ASCII constants and nibble <-> ASCII helpers
// for the UART debug monitor.
package dbg_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } state_e;

  typedef enum logic [1:0] {
    RESP_DATA,
    RESP_ERR,
    RESP_ACK
  } resp_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_QM   = 8'h3F;
  localparam logic [7:0] ASCII_BANG = 8'h21;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? ASCII_ZERO + {4'h0, n} : ASCII_A + {4'h0, n - 4'd10};
  endfunction

  // Letters share their low nibble offset: 'A'/'a' end in 1, so +9 yields 10.
  function automatic hex_t ascii2nib(input logic [7:0] c);
    hex_t h;
    h.valid = 1'b0;
    h.nib   = c[3:0];
    if (c >= 8'h30 && c <= 8'h39) begin
      h.valid = 1'b1;
    end else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) begin
      h.valid = 1'b1;
      h.nib   = c[3:0] + 4'd9;
    end
    return h;
  endfunction

endpackage

// File: rtl/uart_debug_monitor_if.sv
// UART byte-side handshake between the debug monitor (master) and the UART (slave).
interface uart_debug_monitor_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_re;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_busy;

  modport master (input rx_data, rx_valid, tx_busy, output rx_re, tx_data, tx_we);
  modport slave  (output rx_data, rx_valid, tx_busy, input rx_re, tx_data, tx_we);
endinterface

// File: rtl/uart_debug_monitor_guard.sv
// GUARD-cycle holdoff counter: restarts on start, reports expired once it reaches zero.
module dbg_mon_guard #(
  parameter int GUARD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic expired
);
  localparam int CW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(GUARD);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);
endmodule

// File: rtl/uart_debug_monitor.sv
// UART debug monitor: single-char commands select a probe channel and reply with its hex value + CR LF.
// Halt/go/step commands and the halt port are built only when DBGMON_HALT_EN is defined.
module uart_debug_monitor
  import dbg_mon_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int WIDTH = 32,
  parameter int GUARD = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NCH*WIDTH-1:0]                     probe_in,
  uart_debug_monitor_if.master                     uart,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] sel_out,
  output logic [15:0]                              disp_out,
  output logic                                     err
`ifdef DBGMON_HALT_EN
  ,
  output logic                                     halt
`endif
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NDIG = WIDTH / 4;
  localparam int IW   = $clog2(NDIG + 3);

  state_e          state_q, state_d;
  resp_e           resp_q, resp_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            rx_re_q, rx_re_d;
  logic            tx_we_q, tx_we_d;
`ifdef DBGMON_HALT_EN
  logic            halt_q, halt_d;
  logic            step_q, step_d;
`endif

  logic             rx_ok, tx_ok;
  hex_t             hex;
  logic [WIDTH-1:0] ch_word [NCH];
  logic [WIDTH-1:0] digit_sh;
  logic [7:0]       resp_byte;
  logic [IW-1:0]    resp_len;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_word[gi] = probe_in[gi*WIDTH +: WIDTH];
    end
    if (WIDTH >= 16) begin : g_disp_wide
      assign disp_out = ch_word[sel_q][15:0];
    end else begin : g_disp_narrow
      assign disp_out = {{(16-WIDTH){1'b0}}, ch_word[sel_q]};
    end
  endgenerate

  // Guards restart on the registered pulses so the holdoff covers the cycles after the pulse.
  dbg_mon_guard #(.GUARD(GUARD)) u_rx_guard (
    .clk(clk), .rst(rst), .start(rx_re_q), .expired(rx_ok)
  );
  dbg_mon_guard #(.GUARD(GUARD)) u_tx_guard (
    .clk(clk), .rst(rst), .start(tx_we_q), .expired(tx_ok)
  );

  assign hex      = ascii2nib(cmd_q);
  assign digit_sh = shadow_q << {idx_q, 2'b00};
  assign resp_len = (resp_q == RESP_DATA) ? IW'(NDIG + 2) : IW'(3);

  always_comb begin
    resp_byte = ASCII_LF;
    if (resp_q == RESP_DATA) begin
      if (idx_q < IW'(NDIG)) begin
        resp_byte = nib2ascii(digit_sh[WIDTH-1 -: 4]);
      end else if (idx_q == IW'(NDIG)) begin
        resp_byte = ASCII_CR;
      end
    end else begin
      if (idx_q == '0) begin
        resp_byte = (resp_q == RESP_ACK) ? ASCII_BANG : ASCII_QM;
      end else if (idx_q == IW'(1)) begin
        resp_byte = ASCII_CR;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    resp_d    = resp_q;
    cmd_d     = cmd_q;
    tx_data_d = tx_data_q;
    sel_d     = sel_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    rx_re_d   = 1'b0;
    tx_we_d   = 1'b0;
    err       = 1'b0;
`ifdef DBGMON_HALT_EN
    halt_d    = halt_q;
    step_d    = 1'b0;
    if (step_q) begin
      halt_d = 1'b1;
    end
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (uart.rx_valid && rx_ok) begin
          cmd_d   = uart.rx_data;
          rx_re_d = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        idx_d   = '0;
        state_d = ST_LOAD;
        if (hex.valid && ({28'd0, hex.nib} < NCH)) begin
          sel_d    = hex.nib[SELW-1:0];
          shadow_d = ch_word[hex.nib[SELW-1:0]];
          resp_d   = RESP_DATA;
        end else if (cmd_q == 8'h72 || cmd_q == 8'h52) begin
          shadow_d = ch_word[sel_q];
          resp_d   = RESP_DATA;
        end
`ifdef DBGMON_HALT_EN
        else if (cmd_q == 8'h68) begin
          halt_d = 1'b1;
          resp_d = RESP_ACK;
        end else if (cmd_q == 8'h67) begin
          halt_d = 1'b0;
          resp_d = RESP_ACK;
        end else if (cmd_q == 8'h73) begin
          if (halt_q) begin
            halt_d = 1'b0;
            step_d = 1'b1;
          end
          resp_d = RESP_ACK;
        end
`endif
        else begin
          err    = 1'b1;
          resp_d = RESP_ERR;
        end
      end
      ST_LOAD: begin
        tx_data_d = resp_byte;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ok && !uart.tx_busy) begin
          tx_we_d = 1'b1;
          idx_d   = idx_q + IW'(1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = (idx_q == resp_len) ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      resp_q    <= RESP_DATA;
      cmd_q     <= 8'h00;
      tx_data_q <= 8'h00;
      sel_q     <= '0;
      shadow_q  <= '0;
      idx_q     <= '0;
      rx_re_q   <= 1'b0;
      tx_we_q   <= 1'b0;
`ifdef DBGMON_HALT_EN
      halt_q    <= 1'b0;
      step_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      resp_q    <= resp_d;
      cmd_q     <= cmd_d;
      tx_data_q <= tx_data_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      rx_re_q   <= rx_re_d;
      tx_we_q   <= tx_we_d;
`ifdef DBGMON_HALT_EN
      halt_q    <= halt_d;
      step_q    <= step_d;
`endif
    end
  end

  assign uart.rx_re   = rx_re_q;
  assign uart.tx_we   = tx_we_q;
  assign uart.tx_data = tx_data_q;
  assign sel_out      = sel_q;
`ifdef DBGMON_HALT_EN
  assign halt         = halt_q;
`endif
endmodule

// File: tb/tb_uart_debug_monitor.sv
// Self-checking bench for uart_debug_monitor: fixed command table, corner-case sequences,
// then random commands checked against a byte-level reference model.
module tb_uart_debug_monitor;
  localparam int NCH   = 4;
  localparam int WIDTH = 16;
  localparam int GUARD = 4;
  localparam int NDIG  = WIDTH / 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH*WIDTH-1:0] probe_in;
  logic [1:0]           sel_out;
  logic [15:0]          disp_out;
  logic                 err;
`ifdef DBGMON_HALT_EN
  logic                 halt;
`endif

  uart_debug_monitor_if u_if ();

  uart_debug_monitor #(.NCH(NCH), .WIDTH(WIDTH), .GUARD(GUARD)) dut (
    .clk(clk),
    .rst(rst),
    .probe_in(probe_in),
    .uart(u_if),
    .sel_out(sel_out),
    .disp_out(disp_out),
    .err(err)
`ifdef DBGMON_HALT_EN
    ,
    .halt(halt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] tx_log[$];
  int we_cyc[$];
  int we_cnt = 0;
  int err_cnt = 0;
  int halt_low = 0;
  int last_we = -1000;
  int min_gap = 1000;
  int busy_hold = 0;
  int busy_once = 0;

  logic [7:0] exp_q[$];
  bit exp_err;
  int model_sel = 0;
  bit model_halt = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.tx_we) begin
        tx_log.push_back(u_if.tx_data);
        we_cyc.push_back(cyc);
        we_cnt++;
        if (cyc - last_we < min_gap) min_gap = cyc - last_we;
        last_we = cyc;
      end
      if (err) err_cnt++;
`ifdef DBGMON_HALT_EN
      if (!halt) halt_low++;
`endif
    end
  end

  // UART transmitter model: busy for a while after each accepted byte.
  initial begin
    int h;
    u_if.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && u_if.tx_we) begin
        h = (busy_once > 0) ? busy_once : busy_hold;
        busy_once = 0;
        if (h > 0) begin
          u_if.tx_busy = 1'b1;
          repeat (h) @(negedge clk);
          u_if.tx_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_log();
    logic [63:0] v = '0;
    foreach (tx_log[i]) v = {v[55:0], tx_log[i]};
    return v;
  endfunction

  function automatic logic [63:0] pack_exp();
    logic [63:0] v = '0;
    foreach (exp_q[i]) v = {v[55:0], exp_q[i]};
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] chan(input int k);
    return probe_in[k*WIDTH +: WIDTH];
  endfunction

  // Reference model: expected reply bytes from the command rules alone.
  function automatic void push_word(input logic [WIDTH-1:0] w);
    for (int i = NDIG - 1; i >= 0; i--) begin
      int n;
      n = int'(w >> (4 * i)) % 16;
      exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(55 + n));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic void model_cmd(input logic [7:0] c);
    int v = -1;
    exp_q.delete();
    exp_err = 1'b0;
    if (c >= 8'h30 && c <= 8'h39) v = int'(c) - 48;
    else if (c >= 8'h61 && c <= 8'h66) v = int'(c) - 97 + 10;
    else if (c >= 8'h41 && c <= 8'h46) v = int'(c) - 65 + 10;
    if (v >= 0 && v < NCH) begin
      model_sel = v;
      push_word(chan(v));
    end else if (c == 8'h72 || c == 8'h52) begin
      push_word(chan(model_sel));
    end
`ifdef DBGMON_HALT_EN
    else if (c == 8'h68 || c == 8'h67 || c == 8'h73) begin
      if (c == 8'h68) model_halt = 1'b1;
      else if (c == 8'h67) model_halt = 1'b0;
      exp_q.push_back(8'h21);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
`endif
    else begin
      exp_err = 1'b1;
      exp_q.push_back(8'h3F);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic issue_cmd(input logic [7:0] c, output int lat);
    bit seen = 1'b0;
    lat = 0;
    tx_log.delete();
    we_cyc.delete();
    u_if.rx_data  = c;
    u_if.rx_valid = 1'b1;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (u_if.rx_re) seen = 1'b1;
    end
    u_if.rx_valid = 1'b0;
    check("rx_re_seen", 64'(seen), 64'd1);
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (tx_log.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (GUARD + 4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_re"}, 64'(u_if.rx_re), 64'd0);
    check({tag, "_tx_we"}, 64'(u_if.tx_we), 64'd0);
    check({tag, "_tx_data"}, 64'(u_if.tx_data), 64'h00);
    check({tag, "_sel"}, 64'(sel_out), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
`ifdef DBGMON_HALT_EN
    check({tag, "_halt"}, 64'(halt), 64'd0);
`endif
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          len;
    logic [63:0] bytes;
    logic [1:0]  sel;
    int          errs;
  } vec_t;

  vec_t vecs[11];
  logic [15:0] ch_const[4];

  initial begin
    int lat, e0, w0, hl0;
    logic [7:0] cmd;

    ch_const[0] = 16'h7D60;
    ch_const[1] = 16'h0F1E;
    ch_const[2] = 16'hBEEF;
    ch_const[3] = 16'hA5C9;
    vecs[0]  = '{8'h32, 6, 64'h4245_4546_0D0A, 2'd2, 0};
    vecs[1]  = '{8'h37, 3, 64'h3F_0D0A,        2'd2, 1};
    vecs[2]  = '{8'h30, 6, 64'h3744_3630_0D0A, 2'd0, 0};
    vecs[3]  = '{8'h66, 3, 64'h3F_0D0A,        2'd0, 1};
    vecs[4]  = '{8'h31, 6, 64'h3046_3145_0D0A, 2'd1, 0};
    vecs[5]  = '{8'h78, 3, 64'h3F_0D0A,        2'd1, 1};
    vecs[6]  = '{8'h33, 6, 64'h4135_4339_0D0A, 2'd3, 0};
    vecs[7]  = '{8'h72, 6, 64'h4135_4339_0D0A, 2'd3, 0};
    vecs[8]  = '{8'h41, 3, 64'h3F_0D0A,        2'd3, 1};
    vecs[9]  = '{8'h32, 6, 64'h4245_4546_0D0A, 2'd2, 0};
    vecs[10] = '{8'h52, 6, 64'h4245_4546_0D0A, 2'd2, 0};

    rst = 1'b1;
    u_if.rx_valid = 1'b0;
    u_if.rx_data  = 8'h00;
    probe_in = {ch_const[3], ch_const[2], ch_const[1], ch_const[0]};
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_disp", 64'(disp_out), 64'(ch_const[0]));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven commands with fixed probe values
    foreach (vecs[i]) begin
      e0 = err_cnt;
      issue_cmd(vecs[i].cmd, lat);
      wait_bytes(vecs[i].len);
      check("tbl_rx_lat", 64'(lat), 64'd1);
      check("tbl_len", 64'(tx_log.size()), 64'(vecs[i].len));
      check("tbl_bytes", pack_log(), vecs[i].bytes);
      check("tbl_sel", 64'(sel_out), 64'(vecs[i].sel));
      check("tbl_disp", 64'(disp_out), 64'(ch_const[vecs[i].sel]));
      check("tbl_err", 64'(err_cnt - e0), 64'(vecs[i].errs));
      $display("table cmd %02h -> %0d bytes %0h sel=%0d", vecs[i].cmd, tx_log.size(), pack_log(), sel_out);
    end

    // Transmitter busy for 100 cycles after the first byte
    w0 = we_cnt;
    busy_once = 100;
    issue_cmd(8'h32, lat);
    wait_bytes(6);
    check("busy_we_count", 64'(we_cnt - w0), 64'd6);
    check("busy_bytes", pack_log(), 64'h4245_4546_0D0A);
    check("busy_gap", 64'((we_cyc.size() >= 2) && (we_cyc[1] - we_cyc[0] >= 100)), 64'd1);
    $display("busy cmd 32 -> %0d bytes %0h", tx_log.size(), pack_log());

    // Probe changes mid-response must not alter the shadowed digits
    issue_cmd(8'h32, lat);
    wait_bytes(1);
    probe_in[2*WIDTH +: WIDTH] = 16'h1234;
    wait_bytes(6);
    check("shadow_bytes", pack_log(), 64'h4245_4546_0D0A);
    check("shadow_disp_live", 64'(disp_out), 64'h1234);
    $display("shadow cmd 32 -> %0h", pack_log());
    issue_cmd(8'h72, lat);
    wait_bytes(6);
    check("shadow_reread", pack_log(), 64'h3132_3334_0D0A);
    $display("reread cmd 72 -> %0h", pack_log());

`ifdef DBGMON_HALT_EN
    e0 = err_cnt;
    issue_cmd(8'h68, lat);
    wait_bytes(3);
    check("halt_h_bytes", pack_log(), 64'h21_0D0A);
    check("halt_h_level", 64'(halt), 64'd1);
    hl0 = halt_low;
    issue_cmd(8'h73, lat);
    wait_bytes(3);
    check("halt_s_bytes", pack_log(), 64'h21_0D0A);
    check("halt_s_low_cycles", 64'(halt_low - hl0), 64'd1);
    check("halt_s_level", 64'(halt), 64'd1);
    issue_cmd(8'h67, lat);
    wait_bytes(3);
    check("halt_g_bytes", pack_log(), 64'h21_0D0A);
    check("halt_g_level", 64'(halt), 64'd0);
    issue_cmd(8'h73, lat);
    wait_bytes(3);
    check("halt_s_noop", 64'(halt), 64'd0);
    check("halt_no_err", 64'(err_cnt - e0), 64'd0);
    $display("halt sequence h/s/g/s done, halt=%0d", halt);
`else
    e0 = err_cnt;
    issue_cmd(8'h68, lat);
    wait_bytes(3);
    check("nohalt_h_bytes", pack_log(), 64'h3F_0D0A);
    check("nohalt_h_err", 64'(err_cnt - e0), 64'd1);
    $display("cmd 68 without halt support -> %0h", pack_log());
`endif

    // Reset during the third digit aborts the response
    probe_in[2*WIDTH +: WIDTH] = ch_const[2];
    issue_cmd(8'h33, lat);
    wait_bytes(0);
    tx_log.delete();
    wait_bytes(0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    w0 = we_cnt;
    repeat (50) @(negedge clk);
    check("midrst_no_we", 64'(we_cnt - w0), 64'd0);
    issue_cmd(8'h30, lat);
    wait_bytes(6);
    check("midrst_next", pack_log(), 64'h3744_3630_0D0A);
    check("midrst_sel", 64'(sel_out), 64'd0);
    $display("post-reset cmd 30 -> %0h", pack_log());
    model_sel  = 0;
    model_halt = 1'b0;

    // Random commands against the reference model
    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < NCH; c++) probe_in[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       cmd = 8'(8'h30 + $urandom_range(0, 9));
        1:       cmd = 8'(($urandom_range(0, 1) != 0 ? 8'h61 : 8'h41) + $urandom_range(0, 5));
        2:       cmd = ($urandom_range(0, 1) != 0) ? 8'h72 : 8'h52;
        default: cmd = 8'($urandom_range(0, 255));
      endcase
      busy_hold = $urandom_range(0, 8);
      model_cmd(cmd);
      e0 = err_cnt;
      issue_cmd(cmd, lat);
      wait_bytes(exp_q.size());
      check("rnd_rx_lat", 64'(lat), 64'd1);
      check("rnd_len", 64'(tx_log.size()), 64'(exp_q.size()));
      check("rnd_bytes", pack_log(), pack_exp());
      check("rnd_sel", 64'(sel_out), 64'(model_sel));
      check("rnd_disp", 64'(disp_out), 64'(chan(model_sel)));
      check("rnd_err", 64'(err_cnt - e0), 64'(exp_err));
`ifdef DBGMON_HALT_EN
      check("rnd_halt", 64'(halt), 64'(model_halt));
`endif
      $display("random cmd %02h busy=%0d -> %0d bytes %0h sel=%0d", cmd, busy_hold, tx_log.size(), pack_log(), sel_out);
    end

    check("min_we_gap", 64'(min_gap >= GUARD + 2), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_debug_monitor.md
# uart_debug_monitor

Host-driven debug monitor that sits between the CPU probe signals and the UART byte interface in the FPGA debug top. It is the parametrised successor to the switch-selected PC/RX display. It accepts single-character ASCII commands from the UART receive side and selects one of NCH probe channels of WIDTH bits. It answers with the captured word as uppercase hex ASCII followed by CR LF, and exports the selection for the 7-segment display.

## Interface
- NCH, 8, number of probe channels; legal range 1..16
- WIDTH, 32, bits per channel; must be a multiple of 4; NDIG = WIDTH/4 hex digits
- GUARD, 4, cycles to ignore rx_valid/tx_busy after issuing rx_re/tx_we; covers CDC sync latency
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- probe_in  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- rx_data  input  8  received byte, stable while rx_valid high
- rx_valid  input  1  byte available
- rx_re  output  1  one-cycle pulse: byte consumed
- tx_data  output  8  byte to send; stable from tx_we until the next tx_we
- tx_we  output  1  one-cycle pulse: send tx_data
- tx_busy  input  1  transmitter busy
- sel_out  output  $clog2(NCH) (min 1)  current channel
- disp_out  output  16  live probe_in[sel_out][15:0]; zero-extended if WIDTH<16
- err  output  1  one-cycle pulse on invalid command
- halt  output  1  CPU clock-enable hold; present only with DBGMON_HALT_EN

## Operation
- Reset values: rx_re=0, tx_we=0, tx_data=8'h00, sel_out=0, err=0, halt=0, state IDLE, both guard counters expired.
- FSM states: IDLE, DECODE, LOAD, SEND, GAP.
  - IDLE: when rx_valid=1 and rx guard expired, latch rx_data into cmd, pulse rx_re, start rx guard, go to DECODE.
  - DECODE: classifies cmd.
    - Hex char ('0'-'9', 'a'-'f', 'A'-'F') with value < NCH: set sel_out to that value, capture probe word into shadow, queue NDIG digits then 8'h0D, 8'h0A.
    - 'r'/'R': capture the current sel_out channel and queue as above.
    - Hex value >= NCH, or any other byte: pulse err, queue 8'h3F, 8'h0D, 8'h0A. sel_out is unchanged.
  - LOAD: put the next queued byte on tx_data.
  - SEND: wait until tx_busy=0 and tx guard expired, then pulse tx_we and start tx guard. Go to GAP.
  - GAP: if more bytes remain, go to LOAD; otherwise go to IDLE.
- Digits are sent MSB nibble first. Nibble 0-9 maps to 8'h30+n; 10-15 maps to 8'h41+(n-10).
- Shadow capture occurs once per command. Probe changes during a response never alter the digits being sent.
- Commands arriving during a response are not consumed. No rx_re is issued until the FSM returns to IDLE.
- Reset mid-response aborts the response immediately. No further tx_we is issued and the remaining bytes are discarded.

## Timing
- rx_valid seen at edge n (IDLE): rx_re high in cycle n+1; DECODE in cycle n+1.
- First tx_we no earlier than cycle n+3.
- Consecutive tx_we pulses are at least GUARD+2 cycles apart, and each also waits for tx_busy=0.
- tx_busy is ignored for GUARD cycles after each tx_we. rx_valid is ignored for GUARD cycles after each rx_re.
- sel_out updates on the DECODE edge. disp_out follows combinationally from sel_out and probe_in.
- err is a single pulse in the DECODE cycle.

## Configuration
- DBGMON_HALT_EN defined: the halt port and three extra commands exist.
  - 'h' sets halt=1.
  - 'g' clears halt.
  - 's' (only when halt=1): halt=0 for exactly one clk cycle, then returns to 1. When halt=0, 's' is a no-op.
  - All three commands answer 8'h21, 8'h0D, 8'h0A.
- DBGMON_HALT_EN undefined: no halt port; 'h', 'g' and 's' are invalid commands (err pulse plus '?' response).

## Structure
- Package dbg_mon_pkg holds: the state enum; ASCII constants (CR, LF, '?', '!', '0', 'A'); function nib2ascii; function ascii2nib with a valid flag.
- One sub-module, dbg_mon_guard: a GUARD-cycle countdown with start/expired signals, instantiated twice (rx and tx).

## Test plan
- NCH=4, WIDTH=16, ch2=16'hBEEF, send '2' → tx bytes 42 45 45 46 0D 0A; sel_out=2; disp_out=16'hBEEF; err never pulses.
- Send '7' (NCH=4) → err pulse; tx bytes 3F 0D 0A; sel_out stays 2.
- tx_busy held high 100 cycles after the first tx_we → no second tx_we until busy falls; total tx_we count = 6.
- Change ch2 to 16'h1234 after the first digit → remaining digits still E E F; next 'r' sends 31 32 33 34 0D 0A.
- With DBGMON_HALT_EN: 'h' → halt=1, tx 21 0D 0A; 's' → halt low exactly 1 cycle; 'g' → halt=0.
- Assert rst during the third digit → all outputs return to reset values; no further tx_we; the next '0' command works normally.
